// File: rtl/cscv2_ctrl_pkg.sv
// Shared encodings for the CSCv2 run/halt/step sequencer.
package cscv2_ctrl_pkg;

   typedef enum logic [1:0] {
      HALTED  = 2'd0,
      RUNNING = 2'd1,
      STEP    = 2'd2
   } state_e;

   localparam logic [1:0] CAUSE_RESET = 2'd0;
   localparam logic [1:0] CAUSE_REQ   = 2'd1;
   localparam logic [1:0] CAUSE_BP    = 2'd2;
   localparam logic [1:0] CAUSE_LOOP  = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear beats the increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (inc && (q_q != MAX)) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/cscv2_run_ctrl.sv
// Run/halt/step sequencer producing the CSCv2 core-wide clock enable, with
// breakpoint and jump-to-self halting plus a saturating executed-instruction count.
module cscv2_run_ctrl
   import cscv2_ctrl_pkg::*;
#(
   parameter int PC_W        = 8,
   parameter int CNT_W       = 16,
   parameter bit LOOP_DETECT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_req,
   input  logic             step_req,
   input  logic             halt_req,
   input  logic             bp_enable,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic             clr_count,
   input  logic [PC_W-1:0]  pc_val,
   output logic             cpu_en,
   output logic             halted,
   output logic             step_done,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] instr_count,
   output state_e           state_dbg
);

   // run_req/step_req/halt_req are plain levels sampled on every rising edge;
   // there is no acknowledge, the requester watches halted/step_done instead.
   state_e            state_q, state_d;
   logic              skip_bp_q, skip_bp_d;
   logic              last_valid_q, last_valid_d;
   logic [PC_W-1:0]   last_pc_q, last_pc_d;
   logic              step_done_q, step_done_d;
   logic [1:0]        cause_q, cause_d;
   logic              bp_hit, loop_hit, stop;

   assign bp_hit   = bp_enable && (pc_val == bp_addr) && !skip_bp_q;
   assign loop_hit = LOOP_DETECT && last_valid_q && (pc_val == last_pc_q);
   assign stop     = halt_req || bp_hit || loop_hit;

   always_comb begin
      state_d      = state_q;
      skip_bp_d    = skip_bp_q;
      last_valid_d = last_valid_q;
      last_pc_d    = last_pc_q;
      cause_d      = cause_q;
      step_done_d  = 1'b0;
      cpu_en       = 1'b0;
      case (state_q)
         HALTED: begin
            if (step_req) begin
               state_d   = STEP;
               skip_bp_d = 1'b1;
            end else if (run_req) begin
               state_d   = RUNNING;
               skip_bp_d = 1'b1;
            end
         end
         STEP: begin
            cpu_en      = 1'b1;
            state_d     = HALTED;
            step_done_d = 1'b1;
         end
         RUNNING: begin
            cpu_en = !stop;
            if (stop) begin
               state_d = HALTED;
               if (halt_req)    cause_d = CAUSE_REQ;
               else if (bp_hit) cause_d = CAUSE_BP;
               else             cause_d = CAUSE_LOOP;
            end
         end
         default: state_d = HALTED;
      endcase
      // A resume from a breakpoint must execute that address once before it can re-trigger.
      if (cpu_en) begin
         skip_bp_d    = 1'b0;
         last_pc_d    = pc_val;
         last_valid_d = 1'b1;
      end
      if (state_q == HALTED) begin
         last_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= HALTED;
         skip_bp_q    <= 1'b0;
         last_valid_q <= 1'b0;
         last_pc_q    <= '0;
         step_done_q  <= 1'b0;
         cause_q      <= CAUSE_RESET;
      end else begin
         state_q      <= state_d;
         skip_bp_q    <= skip_bp_d;
         last_valid_q <= last_valid_d;
         last_pc_q    <= last_pc_d;
         step_done_q  <= step_done_d;
         cause_q      <= cause_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_count (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_count),
      .inc   (cpu_en),
      .q     (instr_count)
   );

   assign halted     = (state_q == HALTED);
   assign step_done  = step_done_q;
   assign halt_cause = cause_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_cscv2_run_ctrl.sv
// Self-checking bench for cscv2_run_ctrl: cycle vector table, then reset-mid-run
// and counter saturation/clear sequences on narrow and no-loop-detect variants.
module tb_cscv2_run_ctrl;
   import cscv2_ctrl_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       run_req, step_req, halt_req, bp_enable, clr_count;
   logic [7:0] bp_addr, pc_val;

   logic        en_m, hlt_m, sd_m;
   logic [1:0]  cause_m;
   logic [15:0] cnt_m;
   state_e      st_m;

   logic        en_n, hlt_n, sd_n;
   logic [1:0]  cause_n;
   logic [15:0] cnt_n;
   state_e      st_n;

   logic        en_c, hlt_c, sd_c;
   logic [1:0]  cause_c;
   logic [3:0]  cnt_c;
   state_e      st_c;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       run, step, halt, bpe;
      logic [7:0] bpa;
      logic       clr;
      logic [7:0] pc;
      logic       en, hlt, sd;
      logic [1:0] cause;
      logic [15:0] cnt;
   } vec_t;

   vec_t        tbl[$];
   logic [20:0] exp_q[$];

   cscv2_run_ctrl #(.PC_W(8), .CNT_W(16), .LOOP_DETECT(1'b1)) u_main (
      .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .bp_enable(bp_enable), .bp_addr(bp_addr), .clr_count(clr_count), .pc_val(pc_val),
      .cpu_en(en_m), .halted(hlt_m), .step_done(sd_m), .halt_cause(cause_m),
      .instr_count(cnt_m), .state_dbg(st_m)
   );

   cscv2_run_ctrl #(.PC_W(8), .CNT_W(16), .LOOP_DETECT(1'b0)) u_noloop (
      .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .bp_enable(bp_enable), .bp_addr(bp_addr), .clr_count(clr_count), .pc_val(pc_val),
      .cpu_en(en_n), .halted(hlt_n), .step_done(sd_n), .halt_cause(cause_n),
      .instr_count(cnt_n), .state_dbg(st_n)
   );

   cscv2_run_ctrl #(.PC_W(8), .CNT_W(4), .LOOP_DETECT(1'b1)) u_cnt4 (
      .clk(clk), .rst_n(rst_n), .run_req(run_req), .step_req(step_req), .halt_req(halt_req),
      .bp_enable(bp_enable), .bp_addr(bp_addr), .clr_count(clr_count), .pc_val(pc_val),
      .cpu_en(en_c), .halted(hlt_c), .step_done(sd_c), .halt_cause(cause_c),
      .instr_count(cnt_c), .state_dbg(st_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, s, h, be, input logic [7:0] ba, input logic c,
                      input logic [7:0] pc, input logic en, hl, sd,
                      input logic [1:0] ca, input logic [15:0] cn);
      vec_t v;
      v.run = r; v.step = s; v.halt = h; v.bpe = be; v.bpa = ba; v.clr = c; v.pc = pc;
      v.en = en; v.hlt = hl; v.sd = sd; v.cause = ca; v.cnt = cn;
      tbl.push_back(v);
   endtask

   task automatic idle();
      run_req = 0; step_req = 0; halt_req = 0; bp_enable = 0; bp_addr = 0;
      clr_count = 0; pc_val = 0;
   endtask

   initial begin
      logic [20:0] act, e;

      // Each row is one cycle: inputs, then the outputs seen before the next rising edge.
      //   run step halt bpe bpa clr pc     en hlt sd cause cnt
      add(1,0,0,0,8'h00,0,8'h00, 0,1,0,2'd0,16'd0);
      add(0,0,0,0,8'h00,0,8'h00, 1,0,0,2'd0,16'd0);
      add(0,0,0,0,8'h00,0,8'h01, 1,0,0,2'd0,16'd1);
      add(0,0,0,0,8'h00,0,8'h02, 1,0,0,2'd0,16'd2);
      add(0,0,0,1,8'h05,0,8'h03, 1,0,0,2'd0,16'd3);
      add(0,0,0,1,8'h05,0,8'h04, 1,0,0,2'd0,16'd4);
      add(0,0,0,1,8'h05,0,8'h05, 0,0,0,2'd0,16'd5);
      add(0,0,0,1,8'h05,0,8'h05, 0,1,0,2'd2,16'd5);
      add(1,0,0,1,8'h05,0,8'h05, 0,1,0,2'd2,16'd5);
      add(0,0,0,1,8'h05,0,8'h05, 1,0,0,2'd2,16'd5);
      add(0,0,0,1,8'h05,0,8'h06, 1,0,0,2'd2,16'd6);
      add(0,0,1,0,8'h00,0,8'h07, 0,0,0,2'd2,16'd7);
      add(0,0,0,0,8'h00,0,8'h10, 0,1,0,2'd1,16'd7);
      add(0,1,0,0,8'h00,0,8'h10, 0,1,0,2'd1,16'd7);
      add(0,0,0,0,8'h00,0,8'h10, 1,0,0,2'd1,16'd7);
      add(0,0,0,0,8'h00,0,8'h11, 0,1,1,2'd1,16'd8);
      add(1,1,0,0,8'h00,0,8'h11, 0,1,0,2'd1,16'd8);
      add(0,0,0,0,8'h00,0,8'h11, 1,0,0,2'd1,16'd8);
      add(0,0,0,0,8'h00,0,8'h12, 0,1,1,2'd1,16'd9);
      add(0,0,0,0,8'h00,0,8'h12, 0,1,0,2'd1,16'd9);
      add(1,0,0,0,8'h00,0,8'h3E, 0,1,0,2'd1,16'd9);
      add(0,0,0,0,8'h00,0,8'h3E, 1,0,0,2'd1,16'd9);
      add(0,0,0,0,8'h00,0,8'h3F, 1,0,0,2'd1,16'd10);
      add(0,0,0,0,8'h00,0,8'h3F, 0,0,0,2'd1,16'd11);
      add(0,0,0,0,8'h00,0,8'h3F, 0,1,0,2'd3,16'd11);
      add(1,0,0,0,8'h00,0,8'h3F, 0,1,0,2'd3,16'd11);
      add(0,0,0,0,8'h00,0,8'h3F, 1,0,0,2'd3,16'd11);
      add(0,0,0,0,8'h00,0,8'h3F, 0,0,0,2'd3,16'd12);
      add(0,0,0,0,8'h00,0,8'h3F, 0,1,0,2'd3,16'd12);
      add(1,0,0,1,8'h21,0,8'h20, 0,1,0,2'd3,16'd12);
      add(0,0,0,1,8'h21,0,8'h20, 1,0,0,2'd3,16'd12);
      add(0,0,1,1,8'h21,0,8'h21, 0,0,0,2'd3,16'd13);
      add(0,0,0,1,8'h21,0,8'h21, 0,1,0,2'd1,16'd13);

      idle();
      rst_n = 1'b0;
      #3;
      chk("reset_outputs", {11'd0, en_m, hlt_m, sd_m, cause_m, cnt_m}, {11'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0});
      chk("reset_state", {30'd0, st_m}, {30'd0, HALTED});

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < tbl.size(); i++) begin
         if (i > 0) @(negedge clk);
         run_req = tbl[i].run; step_req = tbl[i].step; halt_req = tbl[i].halt;
         bp_enable = tbl[i].bpe; bp_addr = tbl[i].bpa; clr_count = tbl[i].clr;
         pc_val = tbl[i].pc;
         exp_q.push_back({tbl[i].en, tbl[i].hlt, tbl[i].sd, tbl[i].cause, tbl[i].cnt});
         #2;
         act = {en_m, hlt_m, sd_m, cause_m, cnt_m};
         e = exp_q.pop_front();
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL row%0d en/hlt/sd/cause/cnt act=%h exp=%h", i, act, e);
         end
         if (i == 28) begin
            chk("noloop_running", {14'd0, en_n, hlt_n, cnt_n}, {14'd0, 1'b1, 1'b0, 16'd16});
         end
      end

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      idle();
      run_req = 1; pc_val = 8'h40;
      @(negedge clk);
      run_req = 0; pc_val = 8'h41;
      #2;
      chk("pre_reset_running", {30'd0, en_m, hlt_m}, {30'd0, 1'b1, 1'b0});
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset", {11'd0, en_m, hlt_m, sd_m, cause_m, cnt_m}, {11'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0});

      // Saturation on the 4-bit counter, then clear racing an enabled cycle.
      @(negedge clk);
      rst_n = 1'b1;
      run_req = 1; pc_val = 8'h00;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         run_req = 0; pc_val = 8'(k);
      end
      @(negedge clk);
      pc_val = 8'd20; clr_count = 1;
      #2;
      chk("cnt4_saturated", {28'd0, cnt_c}, {28'd0, 4'd15});
      chk("cnt16_twenty", {16'd0, cnt_m}, {16'd0, 16'd20});
      chk("clr_cycle_enabled", {31'd0, en_m}, 32'd1);
      @(negedge clk);
      pc_val = 8'd21; clr_count = 0;
      #2;
      chk("cnt4_cleared", {28'd0, cnt_c}, 32'd0);
      chk("cnt16_cleared", {16'd0, cnt_m}, 32'd0);

      @(negedge clk);
      idle();
      halt_req = 1;
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
